// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU issue stage.
//   Operation codes, operand-B select encoding, MIPS opcode/funct constants,
//   the decoded-control payload struct and the issue FSM state enum.
package alu_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned BSEL_W  = 2;
   localparam int unsigned CNT_W   = 4;

   // ALU operation codes
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
   localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
   localparam logic [OP_W-1:0] OP_NOT  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SHL  = 4'b0111;
   localparam logic [OP_W-1:0] OP_SHR  = 4'b1000;
   localparam logic [OP_W-1:0] OP_NONE = 4'b1111;

   // Operand-B source select
   localparam logic [BSEL_W-1:0] BSEL_RT    = 2'b00;
   localparam logic [BSEL_W-1:0] BSEL_SIMM  = 2'b01;
   localparam logic [BSEL_W-1:0] BSEL_ZIMM  = 2'b10;
   localparam logic [BSEL_W-1:0] BSEL_SHAMT = 2'b11;

   // Opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic              sign;
      logic [BSEL_W-1:0] b_sel;
      logic              illegal;
   } alu_ctl_t;

   localparam alu_ctl_t CTL_RESET =
      '{op: OP_NONE, sign: 1'b0, b_sel: BSEL_RT, illegal: 1'b0};

   localparam alu_ctl_t CTL_ILLEGAL =
      '{op: OP_NONE, sign: 1'b0, b_sel: BSEL_RT, illegal: 1'b1};

   // Build a legal control word
   function automatic alu_ctl_t mk_ctl(input logic [OP_W-1:0] op,
                                       input logic sign,
                                       input logic [BSEL_W-1:0] b_sel);
      alu_ctl_t c;
      c.op      = op;
      c.sign    = sign;
      c.b_sel   = b_sel;
      c.illegal = 1'b0;
      return c;
   endfunction

   // Multi-cycle operations go through the settle counter
   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction-in / ALU-control-out handshake bundle.
//   in_valid/in_ready/instr       : instruction acceptance
//   out_valid/out_ready           : issued-control handshake
//   operation/sign/b_sel/imm_ext/illegal : issued ALU control payload
//   slave = issue stage view, master = producer/consumer view.
interface alu_issue_if #(parameter int unsigned N = 32);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   instr;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    operation;
   logic          sign;
   logic [1:0]    b_sel;
   logic [N-1:0]  imm_ext;
   logic          illegal;

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, operation, sign, b_sel, imm_ext, illegal
   );

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, operation, sign, b_sel, imm_ext, illegal
   );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS instruction -> ALU control decode.
//   i_instr   : instruction word
//   o_ctl     : operation / sign / b_sel / illegal
//   o_imm_ext : immediate extended per b_sel, or zero-extended shamt
module alu_decode
   import alu_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic [INSTR_W-1:0] i_instr,
   output alu_ctl_t           o_ctl,
   output logic [N-1:0]       o_imm_ext
);

   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic [9:0] w_unused_fields;

   assign w_opcode        = i_instr[31:26];
   assign w_funct         = i_instr[5:0];
   assign w_unused_fields = i_instr[25:16];

   // Opcode / funct table
   always_comb begin
      o_ctl = CTL_ILLEGAL;
      if (w_opcode == OPC_RTYPE) begin
         case (w_funct)
            FN_ADD:   o_ctl = mk_ctl(OP_ADD, 1'b1, BSEL_RT);
            FN_ADDU:  o_ctl = mk_ctl(OP_ADD, 1'b0, BSEL_RT);
            FN_SUB:   o_ctl = mk_ctl(OP_SUB, 1'b1, BSEL_RT);
            FN_SUBU:  o_ctl = mk_ctl(OP_SUB, 1'b0, BSEL_RT);
            FN_MULT:  o_ctl = mk_ctl(OP_MUL, 1'b1, BSEL_RT);
            FN_MULTU: o_ctl = mk_ctl(OP_MUL, 1'b0, BSEL_RT);
            FN_DIV:   o_ctl = mk_ctl(OP_DIV, 1'b1, BSEL_RT);
            FN_DIVU:  o_ctl = mk_ctl(OP_DIV, 1'b0, BSEL_RT);
            FN_AND:   o_ctl = mk_ctl(OP_AND, 1'b0, BSEL_RT);
            FN_OR:    o_ctl = mk_ctl(OP_OR,  1'b0, BSEL_RT);
            FN_SLL:   o_ctl = mk_ctl(OP_SHL, 1'b0, BSEL_SHAMT);
            FN_SRL:   o_ctl = mk_ctl(OP_SHR, 1'b0, BSEL_SHAMT);
            default:  ;
         endcase
      end else begin
         case (w_opcode)
            OPC_ADDI:  o_ctl = mk_ctl(OP_ADD, 1'b1, BSEL_SIMM);
            OPC_ADDIU: o_ctl = mk_ctl(OP_ADD, 1'b0, BSEL_SIMM);
            OPC_ANDI:  o_ctl = mk_ctl(OP_AND, 1'b0, BSEL_ZIMM);
            OPC_ORI:   o_ctl = mk_ctl(OP_OR,  1'b0, BSEL_ZIMM);
            OPC_LW,
            OPC_SW:    o_ctl = mk_ctl(OP_ADD, 1'b1, BSEL_SIMM);
            default:   ;
         endcase
      end
   end

   // Immediate extension; rt-sourced and illegal instructions carry zero
   always_comb begin
      case (o_ctl.b_sel)
         BSEL_SIMM:  o_imm_ext = N'($signed(i_instr[15:0]));
         BSEL_ZIMM:  o_imm_ext = N'(i_instr[15:0]);
         BSEL_SHAMT: o_imm_ext = N'(i_instr[10:6]);
         default:    o_imm_ext = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts a MIPS instruction, decodes it, and holds the ALU control
//   until the consumer takes it. Mul/div wait MULDIV_LAT extra cycles first.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_issue_if slave (instruction in, ALU control out)
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned N          = 32,
   parameter int unsigned MULDIV_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   alu_issue_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   alu_ctl_t          r_ctl;
   logic [N-1:0]      r_imm;

   state_e            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   alu_ctl_t          w_ctl_nxt;
   logic [N-1:0]      w_imm_nxt;
   logic              w_in_ready;
   logic              w_load;
   alu_ctl_t          w_dec_ctl;
   logic [N-1:0]      w_dec_imm;

   alu_decode #(.N(N)) u_decode (
      .i_instr   (bus.instr),
      .o_ctl     (w_dec_ctl),
      .o_imm_ext (w_dec_imm)
   );

   // State, counter and issued-control registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ctl   <= CTL_RESET;
         r_imm   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ctl   <= w_ctl_nxt;
         r_imm   <= w_imm_nxt;
      end
   end

   // Next-state / handshake logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ctl_nxt   = r_ctl;
      w_imm_nxt   = r_imm;
      w_in_ready  = 1'b0;
      w_load      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            w_load     = bus.in_valid;
         end
         ST_WAIT: begin
            // Counter at zero: this is the last settle cycle
            if (r_cnt == '0) w_state_nxt = ST_HOLD;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         ST_HOLD: begin
            // Pass-through: a consumed slot can take the next instr at once
            w_in_ready = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) w_load      = 1'b1;
               else              w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_load) begin
         w_ctl_nxt = w_dec_ctl;
         w_imm_nxt = w_dec_imm;
         if (is_muldiv(w_dec_ctl.op)) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LAT_M1;
         end else begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.operation = r_ctl.op;
   assign bus.sign      = r_ctl.sign;
   assign bus.b_sel     = r_ctl.b_sel;
   assign bus.illegal   = r_ctl.illegal;
   assign bus.imm_ext   = r_imm;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter N, default 32: datapath width; the width of imm_ext.
REQ-002 Parameter MULDIV_LAT, default 4, legal range 1..15: settle cycles for multiply/divide operations before out_valid is asserted.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: instr is valid.
REQ-006 Port in_ready, output, 1: block accepts instr this cycle.
REQ-007 Port instr, input, 32: MIPS instruction word.
REQ-008 Port out_valid, output, 1: issued ALU control is valid.
REQ-009 Port out_ready, output... input, 1: consumer accepts the issued control.
REQ-010 Port operation, output, 4: ALU operation code. 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 not, 0111 shl, 1000 shr, 1111 none.
REQ-011 Port sign, output, 1: ALU signed-mode select.
REQ-012 Port b_sel, output, 2: operand-B source. 00 rt, 01 sign-extended imm, 10 zero-extended imm, 11 shamt.
REQ-013 Port imm_ext, output, N: extended immediate, or zero-extended shamt when b_sel=11.
REQ-014 Port illegal, output, 1: instruction not decodable.

Function
REQ-015 Decode R-type (opcode 0x00) funct to operation/sign/b_sel as follows:
- 0x20 → 0000/1/00; 0x21 → 0000/0/00; 0x22 → 0001/1/00; 0x23 → 0001/0/00.
- 0x18 → 0010/1/00; 0x19 → 0010/0/00; 0x1A → 0011/1/00; 0x1B → 0011/0/00.
- 0x24 → 0100/0/00; 0x25 → 0101/0/00.
- 0x00 → 0111/0/11; 0x02 → 1000/0/11.
REQ-016 Decode I-type opcodes to operation/sign/b_sel as follows:
- 0x08 → 0000/1/01; 0x09 → 0000/0/01.
- 0x0C → 0100/0/10; 0x0D → 0101/0/10.
- 0x23 and 0x2B → 0000/1/01.
REQ-017 Any other opcode/funct: operation=1111, sign=0, b_sel=00, imm_ext=0, illegal=1; the instruction is still issued through the handshake.
REQ-018 The FSM has three states:
- IDLE: in_ready=1, out_valid=0.
- WAIT: in_ready=0, out_valid=0; counter running.
- HOLD: out_valid=1.
REQ-019 IDLE with in_valid=1: register the decoded fields. Go to WAIT with counter=MULDIV_LAT-1 for operation 0010/0011; otherwise go to HOLD. Single-cycle ops therefore see out_valid one cycle after acceptance.
REQ-020 WAIT decrements the counter each cycle and enters HOLD in the cycle after the counter reaches 0. Issue-to-out_valid latency is MULDIV_LAT+1 cycles.
REQ-021 HOLD: all outputs are stable until out_ready=1. in_ready = out_ready, giving pass-through acceptance.
REQ-022 HOLD with out_ready=1 and in_valid=1: load the new instruction and go to WAIT or HOLD per REQ-019, with no bubble.
REQ-023 HOLD with out_ready=1 and in_valid=0: go to IDLE.
REQ-024 in_valid while in WAIT is ignored; instr is not sampled.
REQ-025 imm_ext is the decoded extension of instr[15:0] to N bits (sign or zero per b_sel), or instr[10:6] zero-extended when b_sel=11.

Reset
REQ-026 Reset returns the FSM to IDLE asynchronously from any state, including mid-WAIT or mid-HOLD; any pending issue is discarded.
REQ-027 Reset values: out_valid=0, in_ready=1 after release, operation=1111, sign=0, b_sel=00, imm_ext=0, illegal=0, counter=0.

Structure
REQ-028 Package alu_pkg holds the 4-bit operation codes, the b_sel encoding, the opcode/funct constants, and the FSM state enum.
REQ-029 Combinational decode is the sub-module alu_decode (instr → operation, sign, b_sel, imm_ext, illegal). alu_issue holds the FSM, the counter and the output registers.

Verification
REQ-030 Reset asserted mid-WAIT of a div → outputs return to reset values the same cycle; in_ready=1 after release.
REQ-031 instr=0x2128FFFF (addi) accepted, out_ready=1 → next cycle out_valid=1, operation=0000, sign=1, b_sel=01, imm_ext=0xFFFFFFFF.
REQ-032 instr=0x0109001A (div), MULDIV_LAT=4 → out_valid rises exactly 5 cycles after acceptance, operation=0011, sign=1; in_ready=0 throughout.
REQ-033 Back-to-back addu/or/sll with out_ready=1 → one issue per cycle, no bubbles; sll gives b_sel=11 with imm_ext equal to shamt.
REQ-034 out_ready held 0 for 3 cycles in HOLD → outputs stable, in_ready=0, new instr not sampled; release → next instr accepted in the same cycle.
REQ-035 instr=0xFC000000 → illegal=1, operation=1111, handshake completes normally.
